ad_fifo_elastic: RTL and testbench

- Parametrised add/drop elastic bit buffer for the USB2 receive path.
- Absorbs clock drift by lengthening (add) or shortening (drop) the delay of a serial bit stream one bit at a time.
- Replaces a chain of single-bit token cells with a DEPTH-stage shift line, a binary tap pointer and status/flag logic.
- Sits between the bit recovery stage and the NRZI decode / bit-unstuff stage.

---
 rtl/ad_fifo_pkg.sv | 32 +++
 rtl/ad_fifo_ptr_ctrl.sv | 115 +++++++++++
 rtl/ad_fifo_elastic.sv | 88 ++++++++
 tb/tb_ad_fifo_elastic.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ad_fifo_pkg
//  Description : Shared definitions for the ad_fifo_elastic add/drop buffer:
//                default geometry, request-resolution encoding and clog2.
//  Revision    : 1.0 - initial release
// ============================================================================
package ad_fifo_pkg;

    localparam int DEFAULT_DEPTH   = 8;
    localparam int DEFAULT_RST_PTR = DEFAULT_DEPTH / 2;

    // Outcome of the add/drop request pair seen on one bit-strobe edge
    typedef enum logic [1:0] {
        REQ_NONE   = 2'd0,
        REQ_ADD    = 2'd1,
        REQ_DROP   = 2'd2,
        REQ_CANCEL = 2'd3
    } req_e;

    // Ceiling log2, usable in parameter defaults
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : ad_fifo_pkg
`default_nettype wire

// File: rtl/ad_fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ad_fifo_ptr_ctrl
//  Description : Tap-pointer controller for the elastic bit buffer. Resolves
//                add/drop requests, moves a saturating pointer, raises the
//                one-cycle acks, keeps the sticky ovf/udf flags and derives
//                the near_full / near_empty flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad_fifo_ptr_ctrl
    import ad_fifo_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int PTR_W       = clog2(DEPTH),
    parameter int RST_PTR     = DEFAULT_RST_PTR,
    parameter int NEAR_MARGIN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             add_req,
    input  logic             drop_req,
    input  logic             clr_flags,
    output logic [PTR_W-1:0] ptr,
    output logic             add_ack,
    output logic             drop_ack,
    output logic             near_full,
    output logic             near_empty,
    output logic             ovf,
    output logic             udf
);

    localparam logic [PTR_W-1:0] C_PTR_MAX   = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] C_PTR_RST   = PTR_W'(RST_PTR);
    localparam logic [PTR_W-1:0] C_FULL_TH   = PTR_W'(DEPTH - 1 - NEAR_MARGIN);
    localparam logic [PTR_W-1:0] C_EMPTY_TH  = PTR_W'(NEAR_MARGIN);

    req_e             w_req;
    logic [PTR_W-1:0] ptr_d, ptr_q;
    logic             add_ack_d, add_ack_q;
    logic             drop_ack_d, drop_ack_q;
    logic             ovf_d, ovf_q;
    logic             udf_d, udf_q;

    // Classify the request pair; requests only count on bit-strobe edges
    always_comb begin
        w_req = REQ_NONE;
        if (en) begin
            case ({add_req, drop_req})
                2'b10:   w_req = REQ_ADD;
                2'b01:   w_req = REQ_DROP;
                2'b11:   w_req = REQ_CANCEL;
                default: w_req = REQ_NONE;
            endcase
        end
    end

    // Next pointer, acks and sticky flags; a new event on the same edge as
    // clr_flags wins because it is applied after the clear
    always_comb begin
        ptr_d      = ptr_q;
        add_ack_d  = 1'b0;
        drop_ack_d = 1'b0;
        ovf_d      = clr_flags ? 1'b0 : ovf_q;
        udf_d      = clr_flags ? 1'b0 : udf_q;
        case (w_req)
            REQ_ADD: begin
                if (ptr_q != C_PTR_MAX) begin
                    ptr_d     = ptr_q + 1'b1;
                    add_ack_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            REQ_DROP: begin
                if (ptr_q != '0) begin
                    ptr_d      = ptr_q - 1'b1;
                    drop_ack_d = 1'b1;
                end else begin
                    udf_d = 1'b1;
                end
            end
            default: begin
                ptr_d = ptr_q;
            end
        endcase
    end

    // Pointer, ack and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= C_PTR_RST;
            add_ack_q  <= 1'b0;
            drop_ack_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            add_ack_q  <= add_ack_d;
            drop_ack_q <= drop_ack_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign ptr        = ptr_q;
    assign add_ack    = add_ack_q;
    assign drop_ack   = drop_ack_q;
    assign ovf        = ovf_q;
    assign udf        = udf_q;
    assign near_full  = (ptr_q >= C_FULL_TH);
    assign near_empty = (ptr_q <= C_EMPTY_TH);

endmodule : ad_fifo_ptr_ctrl
`default_nettype wire

// File: rtl/ad_fifo_elastic.sv
`default_nettype none
// ============================================================================
//  Module      : ad_fifo_elastic
//  Description : Add/drop elastic bit buffer for the USB2 receive path. A
//                DEPTH-stage shift line is tapped at a movable pointer so the
//                stream delay can grow or shrink by one bit at a time.
//                Optional macro AD_FIFO_INSERT_INVERT_EN: the bit inserted by
//                an add is the complement of the repeated bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad_fifo_elastic
    import ad_fifo_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int PTR_W       = clog2(DEPTH),
    parameter int RST_PTR     = DEPTH / 2,
    parameter int NEAR_MARGIN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic             add_req,
    input  logic             drop_req,
    input  logic             clr_flags,
    output logic             dout,
    output logic             add_ack,
    output logic             drop_ack,
    output logic [PTR_W-1:0] ptr,
    output logic             near_full,
    output logic             near_empty,
    output logic             ovf,
    output logic             udf
);

    logic [DEPTH-1:0] sr_d, sr_q;
    logic             w_tap;

    ad_fifo_ptr_ctrl #(
        .DEPTH       (DEPTH),
        .PTR_W       (PTR_W),
        .RST_PTR     (RST_PTR),
        .NEAR_MARGIN (NEAR_MARGIN)
    ) u_ptr_ctrl (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .add_req    (add_req),
        .drop_req   (drop_req),
        .clr_flags  (clr_flags),
        .ptr        (ptr),
        .add_ack    (add_ack),
        .drop_ack   (drop_ack),
        .near_full  (near_full),
        .near_empty (near_empty),
        .ovf        (ovf),
        .udf        (udf)
    );

    // Shift line advances one position per bit strobe
    always_comb begin
        sr_d = sr_q;
        if (en) begin
            sr_d = {sr_q[DEPTH-2:0], din};
        end
    end

    // Shift line register
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign w_tap = sr_q[ptr];

`ifdef AD_FIFO_INSERT_INVERT_EN
    // add_ack is high exactly on the cycle carrying the inserted bit, so it
    // doubles as the invert register and forces a transition there
    assign dout = w_tap ^ add_ack;
`else
    assign dout = w_tap;
`endif

endmodule : ad_fifo_elastic
`default_nettype wire

// File: tb/tb_ad_fifo_elastic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ad_fifo_elastic
//  Description : Self-checking bench for ad_fifo_elastic (DEPTH=8). A queue
//                of accepted input bits plus an integer delay form the
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ad_fifo_elastic;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic             din = 1'b0;
    logic             add_req = 1'b0;
    logic             drop_req = 1'b0;
    logic             clr_flags = 1'b0;
    logic             dout;
    logic             add_ack;
    logic             drop_ack;
    logic [PTR_W-1:0] ptr;
    logic             near_full;
    logic             near_empty;
    logic             ovf;
    logic             udf;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_hist[$];
    int m_ptr  = DEPTH / 2;
    bit m_aack = 1'b0;
    bit m_dack = 1'b0;
    bit m_ovf  = 1'b0;
    bit m_udf  = 1'b0;

    logic [9:0] obs;
    logic [9:0] expv;

    ad_fifo_elastic #(
        .DEPTH       (DEPTH),
        .PTR_W       (PTR_W),
        .RST_PTR     (DEPTH / 2),
        .NEAR_MARGIN (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .din        (din),
        .add_req    (add_req),
        .drop_req   (drop_req),
        .clr_flags  (clr_flags),
        .dout       (dout),
        .add_ack    (add_ack),
        .drop_ack   (drop_ack),
        .ptr        (ptr),
        .near_full  (near_full),
        .near_empty (near_empty),
        .ovf        (ovf),
        .udf        (udf)
    );

    always #5 clk = ~clk;

    // Expected output: the bit accepted ptr strobes ago (0 while filling)
    function automatic bit m_dout();
        bit b;
        int n;
        n = m_hist.size();
        b = (n > m_ptr) ? m_hist[n - 1 - m_ptr] : 1'b0;
`ifdef AD_FIFO_INSERT_INVERT_EN
        b = b ^ m_aack;
`endif
        return b;
    endfunction

    function automatic logic [9:0] model_vec();
        return {m_dout(), PTR_W'(m_ptr), m_aack, m_dack,
                (m_ptr >= DEPTH - 2), (m_ptr <= 1), m_ovf, m_udf};
    endfunction

    // Drive one clock of stimulus and advance the model, then settle
    task automatic step(input bit e, input bit d, input bit a, input bit dr,
                        input bit c, input bit r);
        reset = r; en = e; din = d; add_req = a; drop_req = dr; clr_flags = c;
        @(posedge clk);
        if (r) begin
            m_hist.delete();
            m_ptr = DEPTH / 2;
            m_aack = 0; m_dack = 0; m_ovf = 0; m_udf = 0;
        end else begin
            m_aack = 0; m_dack = 0;
            if (c) begin m_ovf = 0; m_udf = 0; end
            if (e) begin
                m_hist.push_back(d);
                if (a && !dr) begin
                    if (m_ptr < DEPTH - 1) begin m_ptr++; m_aack = 1; end
                    else m_ovf = 1;
                end else if (dr && !a) begin
                    if (m_ptr > 0) begin m_ptr--; m_dack = 1; end
                    else m_udf = 1;
                end
            end
        end
        #1;
        obs  = {dout, ptr, add_ack, drop_ack, near_full, near_empty, ovf, udf};
        expv = model_vec();
    endtask

    task automatic test_reset();
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 1);
        checks++;
        if (obs !== expv || ptr !== 3'd4 || dout !== 1'b0) begin
            errors++;
            $display("FAIL reset: got %b want %b", obs, expv);
        end
    endtask

    task automatic test_stream();
        bit pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
        for (int i = 0; i < 16; i++) begin
            step(1, (i < 8) ? pat[i] : 1'($urandom), 0, 0, 0, 0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL stream[%0d]: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_add();
        int guard = 0;
        while (m_dout() != 1'b1 && guard < 40) begin
            step(1, 1'($urandom), 0, 0, 0, 0);
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            errors++;
            $display("FAIL add_setup: got dout %b want 1", m_dout());
        end
        step(1, 1'($urandom), 1, 0, 0, 0);
        checks++;
        if (obs !== expv || add_ack !== 1'b1 || ptr !== 3'd5) begin
            errors++;
            $display("FAIL add_ack: got %b want %b", obs, expv);
        end
        for (int i = 0; i < 8; i++) begin
            step(1, 1'($urandom), 0, 0, 0, 0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL add_after[%0d]: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_drop();
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 1'($urandom), 0, 0, 0, 0);
        step(1, 1'($urandom), 0, 1, 0, 0);
        checks++;
        if (obs !== expv || drop_ack !== 1'b1 || ptr !== 3'd3) begin
            errors++;
            $display("FAIL drop_ack: got %b want %b", obs, expv);
        end
        for (int i = 0; i < 8; i++) begin
            step(1, 1'($urandom), 0, 0, 0, 0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL drop_after[%0d]: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_overflow();
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 1'($urandom), 1, 0, 0, 0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL ovf_add[%0d]: got %b want %b", i, obs, expv);
            end
        end
        checks++;
        if (ptr !== 3'd7 || ovf !== 1'b1 || add_ack !== 1'b0 || near_full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state: got ptr %0d ovf %b ack %b want 7 1 0", ptr, ovf, add_ack);
        end
        step(0, 0, 1, 0, 1, 0);
        checks++;
        if (obs !== expv || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want %b", obs, expv);
        end
    endtask

    task automatic test_underflow();
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 1'($urandom), 0, 1, (i == 5), 0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL udf_drop[%0d]: got %b want %b", i, obs, expv);
            end
        end
        checks++;
        if (ptr !== 3'd0 || udf !== 1'b1 || near_empty !== 1'b1) begin
            errors++;
            $display("FAIL udf_state: got ptr %0d udf %b want 0 1", ptr, udf);
        end
        step(1, 1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        checks++;
        if (obs !== expv || add_ack !== 1'b0 || drop_ack !== 1'b0) begin
            errors++;
            $display("FAIL cancel: got %b want %b", obs, expv);
        end
    endtask

    task automatic test_en_freeze();
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 1'($urandom), 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1'($urandom), 1, 0, 0, 0);
            checks++;
            if (obs !== expv || ptr !== 3'd4 || add_ack !== 1'b0) begin
                errors++;
                $display("FAIL en_freeze[%0d]: got %b want %b", i, obs, expv);
            end
        end
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        checks++;
        if (obs !== expv || ptr !== 3'd4 || dout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b want %b", obs, expv);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 4) != 0), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0));
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random[%0d]: got %b want %b", i, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_add();
        test_drop();
        test_overflow();
        test_underflow();
        test_en_freeze();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ad_fifo_elastic
`default_nettype wire
